// File: rtl/countdown_timer_bcd.sv
// rtl/countdown_timer_bcd.sv - BCD countdown timer with prescaler, reload, bonus time and sticky time-up flag
// The count always holds valid BCD; loads are clamped per digit and additions saturate at all nines.

module countdown_timer_bcd #(
    parameter int NUM_DIGITS  = 2,
    parameter int TICK_CYCLES = 50000000,
    parameter logic [4*NUM_DIGITS-1:0] RESET_VALUE    = 8'h30,
    parameter logic [4*NUM_DIGITS-1:0] BONUS_VALUE    = 8'h05,
    parameter logic [4*NUM_DIGITS-1:0] WARN_THRESHOLD = 8'h05
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Enable,
    input  logic                    Reconfig,
    input  logic [4*NUM_DIGITS-1:0] LoadValue,
    input  logic                    Bonus,
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic                    Tick,
    output logic                    TimeUp,
    output logic                    Warning
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

    logic [W-1:0]  count_q, count_d;
    logic [PW-1:0] prescaler_q, prescaler_d;
    logic          tick_q, tick_d;
    logic          time_up_q, time_up_d;

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple borrow from the ones digit upward; a zero digit becomes nine.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_add_sat(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   s;
        logic         carry;
        r     = '0;
        carry = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, carry};
            if (s > 5'd9) begin
                r[4*i +: 4] = 4'(s - 5'd10);
                carry       = 1'b1;
            end else begin
                r[4*i +: 4] = s[3:0];
                carry       = 1'b0;
            end
        end
        if (carry) r = {NUM_DIGITS{4'h9}};
        return r;
    endfunction

    logic [W-1:0] bonus_clamped;
    logic [W-1:0] load_clamped;
    logic [W-1:0] next_count;
    logic         running;
    logic         at_wrap;

    assign bonus_clamped = bcd_clamp(BONUS_VALUE);
    assign load_clamped  = bcd_clamp(LoadValue);
    assign running       = Enable && !time_up_q;
    assign at_wrap       = running && (prescaler_q == PRE_MAX);

    always_comb begin
        prescaler_d = prescaler_q;
        count_d     = count_q;
        tick_d      = 1'b0;
        time_up_d   = time_up_q;
        next_count  = count_q;

        if (Reconfig) begin
            count_d     = load_clamped;
            prescaler_d = '0;
            time_up_d   = (load_clamped == '0);
        end else if (time_up_q) begin
            prescaler_d = '0;
        end else begin
            if (running) begin
                prescaler_d = at_wrap ? '0 : prescaler_q + 1'b1;
            end
            // Decrement first so a coincident bonus can rescue a count that would hit zero.
            if (at_wrap) begin
                next_count = (count_q == '0) ? count_q : bcd_dec(count_q);
                tick_d     = 1'b1;
            end
            if (Bonus) begin
                next_count = bcd_add_sat(next_count, bonus_clamped);
            end
            count_d = next_count;
            if (at_wrap || Bonus) begin
                time_up_d = (next_count == '0);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_q     <= RESET_VALUE;
            prescaler_q <= '0;
            tick_q      <= 1'b0;
            time_up_q   <= 1'b0;
        end else begin
            count_q     <= count_d;
            prescaler_q <= prescaler_d;
            tick_q      <= tick_d;
            time_up_q   <= time_up_d;
        end
    end

    assign Digits  = count_q;
    assign Tick    = tick_q;
    assign TimeUp  = time_up_q;
    assign Warning = (count_q <= WARN_THRESHOLD) && !time_up_q;

endmodule

// File: doc/countdown_timer_bcd.md
COUNTDOWN_TIMER_BCD -- requirements
Module: countdown_timer_bcd

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of BCD digits (1..8).
REQ-002 Parameter TICK_CYCLES, default 50000000, Clock cycles per one-second tick (>=2).
REQ-003 Parameter RESET_VALUE, default 8'h30, BCD count loaded by Reset; width 4*NUM_DIGITS; SHALL be nonzero.
REQ-004 Parameter BONUS_VALUE, default 8'h05, BCD amount added on Bonus; width 4*NUM_DIGITS.
REQ-005 Parameter WARN_THRESHOLD, default 8'h05, BCD value at or below which Warning asserts; width 4*NUM_DIGITS.
REQ-006 Clock  input  1  single clock; all state updates on rising edge.
REQ-007 Reset  input  1  synchronous, active-high.
REQ-008 Enable  input  1  high = count runs; low = pause.
REQ-009 Reconfig  input  1  single-cycle load request.
REQ-010 LoadValue  input  4*NUM_DIGITS  BCD value captured on Reconfig.
REQ-011 Bonus  input  1  single-cycle add-time request.
REQ-012 Digits  output  4*NUM_DIGITS  current BCD count; digit 0 = bits [3:0] (ones).
REQ-013 Tick  output  1  registered one-cycle pulse per elapsed second.
REQ-014 TimeUp  output  1  registered, sticky; count has reached zero.
REQ-015 Warning  output  1  combinational from registers: count <= WARN_THRESHOLD and TimeUp low.

Function
REQ-016 Prescaler counts 0..TICK_CYCLES-1 only while Enable high and TimeUp low; holds (not clears) while paused.
REQ-017 When prescaler = TICK_CYCLES-1 and counting, prescaler wraps to 0 and Tick is high the next cycle for exactly one cycle.
REQ-018 Each Tick event decrements the count by 1 in BCD: a digit at 0 becomes 9 and borrows from the next-higher digit; decrement happens on the same edge Tick registers high.
REQ-019 When a decrement yields all-zero count, TimeUp SHALL be high on the same edge the count becomes zero.
REQ-020 While TimeUp high: count frozen at zero, prescaler held at 0, no Tick, Bonus ignored.
REQ-021 Reconfig: count <= LoadValue, any digit >9 clamped to 9; prescaler <= 0; TimeUp <= 1 if loaded value is zero, else 0; no Tick that cycle.
REQ-022 Bonus (TimeUp low): count <= count + BONUS_VALUE in BCD with per-digit carry, saturating at all-9s.
REQ-023 Tick and Bonus on same edge: decrement first, then add BONUS_VALUE with saturation; TimeUp asserts only if final value is zero.
REQ-024 Priority: Reset > Reconfig > (Tick/Bonus); Reconfig on the same edge as a tick boundary discards that tick.
REQ-025 Enable does not gate Bonus or Reconfig.
REQ-026 Digits never holds a non-BCD digit in any cycle.

Reset
REQ-027 On Reset: Digits <= RESET_VALUE, prescaler <= 0, Tick <= 0, TimeUp <= 0, regardless of other inputs.
REQ-028 Reset asserted mid-count or while TimeUp high SHALL restore REQ-027 state on the next edge; counting resumes the cycle after Reset deasserts if Enable high.

Verification (TICK_CYCLES=4, NUM_DIGITS=2, defaults otherwise)
REQ-029 Reset, Enable=1 for 40 cycles -> Tick every 4th cycle; Digits 30->29->...->20 (borrow 30->29 checked); Warning low.
REQ-030 Reconfig LoadValue=8'h02, Enable=1 -> Digits 02, 01, 00; TimeUp high with Digits=00; Warning high at 02 and 01, low once TimeUp; no further Tick for 20 cycles.
REQ-031 Enable toggled low for 10 cycles with prescaler at 2 -> count and prescaler hold; tick fires 2 cycles after Enable returns high.
REQ-032 Load 8'h97, Bonus -> 99 (saturated); Load 8'h01, Bonus coincident with tick edge -> 05, TimeUp stays low.
REQ-033 Load 8'hA3 -> Digits=93; Load 8'h00 -> TimeUp high next edge; Bonus while TimeUp -> no change; Reset -> Digits=30, TimeUp=0.
REQ-034 Reconfig on a tick-boundary edge -> loaded value held, no Tick pulse, next Tick 4 cycles later.
